// File: rtl/byte_div_sequencer.sv
// Issue/collect sequencer around a combinational byte divider: walks the byte lanes of a
// 64-bit operand pair, one lane per cycle. Optional macro DIV_EARLY_EXIT_EN skips masked lanes.
module byte_div_sequencer #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [8*NUM_LANES-1:0] op_a,
  input  logic [8*NUM_LANES-1:0] op_b,
  input  logic                   sel_mod,
  input  logic [NUM_LANES-1:0]   lane_mask,
  output logic [7:0]             div_a,
  output logic [7:0]             div_b,
  input  logic [7:0]             div_quotient,
  input  logic [7:0]             div_remainder,
  input  logic                   div_by_0,
  output logic [8*NUM_LANES-1:0] result,
  output logic [NUM_LANES-1:0]   dbz_flags,
  output logic                   result_valid,
  input  logic                   result_ready
);

  localparam int unsigned W = 8 * NUM_LANES;

  typedef enum logic [1:0] {IDLE, LANE, DONE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         a_q, b_q, result_q;
  logic [NUM_LANES-1:0] mask_q, dbz_q;
  logic                 sel_q;
  logic [CNT_W-1:0]     cnt_q, start_cnt, next_cnt;
  logic                 accept, last_lane;
  logic [7:0]           lane_byte;

`ifdef DIV_EARLY_EXIT_EN
  // Lowest set mask bit at or above 'from'; msb of the return is the found flag.
  function automatic logic [CNT_W:0] find_lane(input logic [NUM_LANES-1:0] m,
                                               input int unsigned from);
    logic             found;
    logic [CNT_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && i >= from && m[i]) begin
        found = 1'b1;
        idx   = CNT_W'(i);
      end
    end
    return {found, idx};
  endfunction

  logic [CNT_W:0] first_hit, next_hit;
  assign first_hit = find_lane(lane_mask, 32'd0);
  assign next_hit  = find_lane(mask_q, 32'(cnt_q) + 32'd1);
  assign start_cnt = first_hit[CNT_W-1:0];
  assign next_cnt  = next_hit[CNT_W-1:0];
  assign last_lane = !next_hit[CNT_W];
`else
  assign start_cnt = '0;
  assign next_cnt  = cnt_q + CNT_W'(1);
  assign last_lane = (cnt_q == CNT_W'(NUM_LANES - 1));
`endif

  assign accept    = (state_q == IDLE) && start_valid;
  assign lane_byte = mask_q[cnt_q] ? (sel_q ? div_remainder : div_quotient) : 8'h00;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_EARLY_EXIT_EN
          state_d = first_hit[CNT_W] ? LANE : DONE;
`else
          state_d = LANE;
`endif
        end
      end
      LANE:    if (last_lane) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; divider operands come only from latched copies
  always_comb begin
    start_ready  = 1'b0;
    result_valid = 1'b0;
    div_a        = 8'h00;
    div_b        = 8'h00;
    case (state_q)
      IDLE: start_ready = 1'b1;
      LANE: begin
        div_a = a_q[8*int'(cnt_q) +: 8];
        div_b = b_q[8*int'(cnt_q) +: 8];
      end
      DONE:    result_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, lane counter and result assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      mask_q   <= '0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= op_a;
            b_q      <= op_b;
            mask_q   <= lane_mask;
            sel_q    <= sel_mod;
            cnt_q    <= start_cnt;
            result_q <= '0;
            dbz_q    <= '0;
          end
        end
        LANE: begin
          result_q[8*int'(cnt_q) +: 8] <= lane_byte;
          dbz_q[cnt_q]                 <= mask_q[cnt_q] & div_by_0;
          cnt_q                        <= last_lane ? '0 : next_cnt;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign dbz_flags = dbz_q;

endmodule
